// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB, combinational datapath controls.
// 3-5 cycles per instruction plus memory wait cycles; stall holds FETCH, MEM waits on memReady up to MEM_TIMEOUT.
module multicycle_ctrl #(
  parameter int INSN_W      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INSN_W-1:0] instruction,
  input  logic [4:0]        psrFlags,
  input  logic              memReady,
  input  logic              stall,
  output logic              pcEn,
  output logic              pcIncOrSet,
  output logic              irEn,
  output logic              rfWe,
  output logic              pcRegSel,
  output logic              r2ImSel,
  output logic              brWe,
  output logic              wbRegAlu,
  output logic              psrEn,
  output logic [1:0]        immTypeSel,
  output logic              memReq,
  output logic              memWe,
  output logic              memErr,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic [3:0] opcode, ext, cond;
  logic       is_load, is_store, is_jmp, is_cmp, is_bcond, no_wb_write, cond_taken;
  logic       flag_c, flag_z, flag_n;
  logic       unused_bits;

  assign opcode = instruction[INSN_W-1 -: 4];
  assign ext    = instruction[7:4];
  assign cond   = instruction[11:8];
  assign flag_c = psrFlags[0];
  assign flag_z = psrFlags[3];
  assign flag_n = psrFlags[4];
  assign unused_bits = ^{instruction, psrFlags};
  assign state  = cur;

  assign is_load  = (opcode == 4'b0100) && (ext == 4'b0000);
  assign is_store = (opcode == 4'b0100) && (ext == 4'b0100);
  assign is_jmp   = (opcode == 4'b0100) && (ext == 4'b1100);
  assign is_cmp   = ((opcode == 4'b0000) && (ext == 4'b1011)) || (opcode == 4'b1011);
  assign is_bcond = (opcode == 4'b1100);
  // Opcodes with no register result, including reserved 0100 sub-opcodes
  assign no_wb_write = (opcode == 4'b0110) || (opcode == 4'b0111) ||
                       (opcode == 4'b1010) || (opcode == 4'b1110) ||
                       ((opcode == 4'b0100) && !is_load && !is_store && !is_jmp);

  always_comb begin
    cond_taken = 1'b0;
    case (cond)
      4'b0000: cond_taken = flag_z;
      4'b0001: cond_taken = !flag_z;
      4'b0010: cond_taken = flag_c;
      4'b0011: cond_taken = !flag_c;
      4'b0110: cond_taken = flag_n;
      4'b0111: cond_taken = !flag_n;
      4'b1110: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    pcEn       = 1'b0;
    pcIncOrSet = 1'b0;
    irEn       = 1'b0;
    rfWe       = 1'b0;
    pcRegSel   = 1'b1;
    r2ImSel    = 1'b0;
    brWe       = 1'b0;
    wbRegAlu   = 1'b1;
    psrEn      = 1'b0;
    immTypeSel = 2'b00;
    memReq     = 1'b0;
    memWe      = 1'b0;
    nxt        = FETCH;
    case (cur)
      FETCH:  nxt = stall ? FETCH : DECODE;
      DECODE: begin
        irEn = 1'b1;
        nxt  = EXEC;
      end
      EXEC: begin
        psrEn   = 1'b1;
        r2ImSel = 1'b1;
        case (opcode)
          4'b0001, 4'b0010, 4'b0011, 4'b1101: immTypeSel = 2'b10;
          4'b0101, 4'b1001, 4'b1011, 4'b1100: immTypeSel = 2'b01;
          default:                            immTypeSel = 2'b00;
        endcase
        if ((opcode == 4'b0000) || (opcode == 4'b0100)) r2ImSel = 1'b0;
        if (is_jmp)   immTypeSel = 2'b11;
        if (is_bcond) pcRegSel   = 1'b0;
        if (is_cmp) begin
          pcEn = 1'b1;
          nxt  = FETCH;
        end else if (is_load || is_store) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        memReq = 1'b1;
        memWe  = is_store;
        // A late memReady on the timeout cycle still completes normally
        if (memReady) begin
          brWe = is_store;
          nxt  = WB;
        end else if (wait_cnt == TMO) begin
          pcEn = 1'b1;
          nxt  = FETCH;
        end else begin
          nxt = MEM;
        end
      end
      WB: begin
        pcEn = 1'b1;
        rfWe = 1'b1;
        nxt  = FETCH;
        if (is_load)  wbRegAlu = 1'b0;
        if (is_store) rfWe = 1'b0;
        if (is_jmp) begin
          rfWe       = 1'b0;
          pcIncOrSet = 1'b1;
        end
        if (is_bcond) begin
          rfWe       = 1'b0;
          pcIncOrSet = cond_taken;
        end
        if (no_wb_write) rfWe = 1'b0;
      end
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur      <= FETCH;
      wait_cnt <= 8'd0;
      memErr   <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == EXEC) begin
        wait_cnt <= 8'd0;
      end else if ((cur == MEM) && !memReady) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((cur == MEM) && !memReady && (wait_cnt == TMO)) memErr <= 1'b1;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: INSN_W, default 16, instruction width (>=16); opcode = instruction[INSN_W-1:INSN_W-4], ext = [7:4], cond = [11:8].
REQ-002 Parameter: MEM_TIMEOUT, default 15, max MEM-state wait cycles before abort (1..255).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 instruction  in  INSN_W  current IR contents.
REQ-006 psrFlags  in  5  bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
REQ-007 memReady  in  1  memory completes request this cycle.
REQ-008 stall  in  1  holds FSM in FETCH.
REQ-009 pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel, brWe, wbRegAlu, psrEn  out  1 each  datapath controls (0 = increment/pc/reg/mem as applicable).
REQ-010 immTypeSel  out  2  00 raw, 01 sign-ext, 10 zero-ext, 11 jump.
REQ-011 memReq, memWe  out  1 each  memory request / write strobe.
REQ-012 memErr  out  1  sticky timeout flag.
REQ-013 state  out  3  current state encoding.

Function
REQ-014 States SHALL be FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100; encodings 101-111 SHALL go to FETCH next cycle with all outputs default.
REQ-015 Outputs SHALL be combinational from state/inputs; defaults every cycle: all 0 except pcRegSel=1, wbRegAlu=1; memErr registered.
REQ-016 FETCH: stall=1 -> stay; else -> DECODE.
REQ-017 DECODE: irEn=1 -> EXEC.
REQ-018 EXEC: psrEn=1; r2ImSel=1 and immTypeSel per opcode: 0001/0010/0011/1101 -> 10; 0101/1001/1011/1100 -> 01; 1000/1111 -> 00; opcode 0000 and 0100 -> r2ImSel=0; 0100 with ext 1100 -> immTypeSel=11; 1100 -> pcRegSel=0.
REQ-019 EXEC next state: CMP (0000, ext 1011) or CMPI (1011) -> pcEn=1, pcIncOrSet=0, -> FETCH; LOAD (0100/0000) or STORE (0100/0100) -> MEM; all others -> WB.
REQ-020 MEM: memReq=1; memWe=1 for STORE; 8-bit wait counter cleared on MEM entry, +1 per cycle without memReady.
REQ-021 MEM with memReady=1 -> WB; STORE additionally brWe=1 that cycle.
REQ-022 MEM with counter==MEM_TIMEOUT and memReady=0 -> memErr<=1, pcEn=1, pcIncOrSet=0, -> FETCH; memReady=1 on that same cycle SHALL win (normal completion).
REQ-023 WB: pcEn=1, rfWe=1 default -> FETCH; LOAD wbRegAlu=0; STORE rfWe=0; JMP (0100/1100) rfWe=0, pcIncOrSet=1.
REQ-024 WB BCOND (1100): rfWe=0; pcIncOrSet=1 iff cond taken: 0000 Z=1, 0001 Z=0, 0010 C=1, 0011 C=0, 0110 N=1, 0111 N=0, 1110 always; other codes never taken.
REQ-025 Opcodes 0110, 0111, 1010, 1110 and undefined 0100 ext SHALL go EXEC->WB with rfWe=0, pcIncOrSet=0.
REQ-026 Latency: CMP/CMPI 3 cycles; ALU/branch/jump 4; LOAD/STORE 4 + wait cycles + 1; stall adds 1 per cycle.

Reset
REQ-027 reset=0 SHALL asynchronously set state=FETCH, wait counter=0, memErr=0; outputs revert to defaults immediately, including mid-MEM (memReq drops same cycle).
REQ-028 After reset release, first rising edge with stall=0 SHALL enter DECODE.

Verification
REQ-029 ADDI 0x5123, stall=0 -> states 000,001,010,100,000; WB: rfWe=1, pcEn=1, pcIncOrSet=0; EXEC: immTypeSel=01, r2ImSel=1.
REQ-030 LOAD 0x4102, memReady high on 3rd MEM cycle -> MEM 3 cycles, then WB wbRegAlu=0, rfWe=1; memErr=0.
REQ-031 STORE 0x4142, memReady never, MEM_TIMEOUT=15 -> 16 MEM cycles memReq=1 memWe=1, then FETCH with memErr=1, rfWe never asserted.
REQ-032 BCOND 0xC0F5 (cond 0000) with Z=1 -> WB pcIncOrSet=1; Z=0 -> pcIncOrSet=0; rfWe=0 both.
REQ-033 CMPI 0xB105 -> EXEC pcEn=1, psrEn=1, next FETCH; no WB cycle.
REQ-034 reset=0 pulsed mid-MEM between edges -> state=000, memReq=0, memErr=0 before next edge; stall=1 after release holds FETCH.
